// File: rtl/axis_frame_gen.sv
// AXI-stream frame generator: deterministic payload (seed + beat index), pause/abort at frame
// boundaries, frame/beat statistics. Define AXIS_FRAME_GEN_BADFRAME_EN to mark bad frames on tuser.
module axis_frame_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned KEEP_W = (DATA_W + 7) / 8,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DST_W  = 8,
    parameter int unsigned USR_W  = 1,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned GAP    = 0
) (
    input  logic              clk,
    input  logic              srst_n,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [ID_W-1:0]   m_axis_tid,
    output logic [DST_W-1:0]  m_axis_tdest,
    output logic [USR_W-1:0]  m_axis_tuser,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [15:0]       frame_cnt,
    input  logic [DATA_W-1:0] seed,
    input  logic [DST_W-1:0]  dest,
    input  logic [7:0]        bad_every,
    input  logic              abort,
    input  logic              pause_req,
    output logic              pause_ack,
    output logic              busy,
    output logic              done,
    output logic [31:0]       stat_frames,
    output logic [31:0]       stat_beats
);

    // Frame index must cover both the 16-bit frame count compare and the tid width.
    localparam int unsigned FW = (ID_W > 16) ? ID_W : 16;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StGap, StPause} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]  seed_q, seed_d;
    logic [DST_W-1:0]   dest_q, dest_d;
    logic [LEN_W-1:0]   k_q, k_d;
    logic [FW-1:0]      f_q, f_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [31:0]        frames_q, frames_d;
    logic [31:0]        beats_q, beats_d;

    logic               tvalid_q, tvalid_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic [KEEP_W-1:0]  tkeep_q, tkeep_d;
    logic               tlast_q, tlast_d;
    logic [ID_W-1:0]    tid_q, tid_d;
    logic [DST_W-1:0]   tdest_q, tdest_d;
    logic [USR_W-1:0]   tuser_q, tuser_d;
    logic               pause_ack_q, pause_ack_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;

`ifdef AXIS_FRAME_GEN_BADFRAME_EN
    logic [7:0]         be_q, be_d;
`else
    logic               unused_bad_every;
    assign unused_bad_every = ^bad_every;
`endif

    assign accept = tvalid_q && m_axis_tready;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        seed_d   = seed_q;
        dest_d   = dest_q;
        k_d      = k_q;
        f_d      = f_q;
        gap_d    = gap_q;
        frames_d = frames_q;
        beats_d  = beats_q;
        done_d   = 1'b0;
`ifdef AXIS_FRAME_GEN_BADFRAME_EN
        be_d     = be_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = (frame_len == '0) ? LEN_W'(1) : frame_len;
                    cnt_d   = frame_cnt;
                    seed_d  = seed;
                    dest_d  = dest;
                    k_d     = '0;
                    f_d     = '0;
                    state_d = StSend;
`ifdef AXIS_FRAME_GEN_BADFRAME_EN
                    be_d    = bad_every;
`endif
                end
            end
            StSend: begin
                if (accept) begin
                    beats_d = beats_q + 32'd1;
                    // tlast_q was derived from the latched length, so it marks k == len-1.
                    if (tlast_q) begin
                        k_d      = '0;
                        f_d      = f_q + FW'(1);
                        frames_d = frames_q + 32'd1;
                        if (((cnt_q != '0) && (f_q + FW'(1) == FW'(cnt_q))) || abort) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else if (pause_req) begin
                            state_d = StPause;
                        end else if (GAP != 0) begin
                            state_d = StGap;
                            gap_d   = '0;
                        end
                    end else begin
                        k_d = k_q + LEN_W'(1);
                    end
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (gap_q == GW'(GAP - 1)) begin
                    state_d = pause_req ? StPause : StSend;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            StPause: begin
                if (abort) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (!pause_req) begin
                    state_d = StSend;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from next-state values; a stalled beat keeps k/f unchanged.
        tvalid_d    = (state_d == StSend);
        tdata_d     = seed_d + DATA_W'(k_d);
        tkeep_d     = tvalid_d ? {KEEP_W{1'b1}} : '0;
        tlast_d     = tvalid_d && (k_d == len_d - LEN_W'(1));
        tid_d       = f_d[ID_W-1:0];
        tdest_d     = dest_d;
        tuser_d     = '0;
`ifdef AXIS_FRAME_GEN_BADFRAME_EN
        tuser_d[0]  = tlast_d && (be_d != '0) && (((f_d + FW'(1)) % FW'(be_d)) == '0);
`endif
        pause_ack_d = (state_d == StPause);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            seed_q      <= '0;
            dest_q      <= '0;
            k_q         <= '0;
            f_q         <= '0;
            gap_q       <= '0;
            frames_q    <= '0;
            beats_q     <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tid_q       <= '0;
            tdest_q     <= '0;
            tuser_q     <= '0;
            pause_ack_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef AXIS_FRAME_GEN_BADFRAME_EN
            be_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            dest_q      <= dest_d;
            k_q         <= k_d;
            f_q         <= f_d;
            gap_q       <= gap_d;
            frames_q    <= frames_d;
            beats_q     <= beats_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            tid_q       <= tid_d;
            tdest_q     <= tdest_d;
            tuser_q     <= tuser_d;
            pause_ack_q <= pause_ack_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef AXIS_FRAME_GEN_BADFRAME_EN
            be_q        <= be_d;
`endif
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tdest  = tdest_q;
    assign m_axis_tuser  = tuser_q;
    assign pause_ack     = pause_ack_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign stat_frames   = frames_q;
    assign stat_beats    = beats_q;

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

Transmit-side AXI-stream frame generator that drives the input of a stream FIFO or any AXI-stream sink. On a start pulse it emits a programmed number of frames of programmed length. Payload is deterministic, so a downstream checker can verify it. The generator obeys tready backpressure, honours pause and abort requests at frame boundaries, and reports frame/beat statistics. It is used as the traffic source in stream-path bring-up and in FIFO verification benches.

## Interface
- DATA_W, 8, tdata width in bits
- KEEP_W, (DATA_W+7)/8, tkeep width
- ID_W, 8, tid width
- DST_W, 8, tdest width
- USR_W, 1, tuser width
- LEN_W, 16, frame-length field width (beats)
- GAP, 0, idle cycles inserted between frames (0 = back-to-back)
- clk  in  1  clock
- srst_n  in  1  reset, synchronous, active-low
- m_axis  axis_full_if.out  DATA_W/KEEP_W/ID_W/DST_W/USR_W  AXI-stream output
- start  in  1  one-cycle pulse; latches config, begins generation
- frame_len  in  LEN_W  beats per frame; 0 is treated as 1
- frame_cnt  in  16  frames to send; 0 = continuous until abort
- seed  in  DATA_W  payload base value
- dest  in  DST_W  tdest value for all beats
- bad_every  in  8  bad-frame injection period (see Configuration)
- abort  in  1  level; stop after the current frame
- pause_req  in  1  level; hold off at next frame boundary
- pause_ack  out  1  high while paused
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse on completion
- stat_frames  out  32  frames completed since reset (wraps)
- stat_beats  out  32  beats accepted since reset (wraps)

## Operation
- States: IDLE, SEND, GAP, PAUSE.
- IDLE: on start, latch frame_len, frame_cnt, seed, dest, and bad_every. Clear beat index k and frame index f. Go to SEND. start is ignored when not in IDLE.
- SEND: tvalid=1. Outputs are as follows:
  - tdata = seed + k, modulo 2^DATA_W.
  - tkeep = all ones.
  - tid = f[ID_W-1:0].
  - tdest = latched dest.
  - tlast = (k == len-1).
- Handshake: a beat is accepted on tvalid && tready. While tvalid is high and tready is low, every m_axis field holds stable. tvalid is never dropped before acceptance.
- On accepting a non-last beat: k++.
- On accepting the last beat: k=0, f++, stat_frames++. Then the next state is chosen in this priority order:
  - IDLE with done, if frame_cnt≠0 and f+1==frame_cnt, or if abort=1.
  - PAUSE, if pause_req=1.
  - GAP, if GAP>0.
  - Otherwise stay in SEND.
- GAP: tvalid=0 for exactly GAP cycles, then go to SEND. Exception: if pause_req is high on the final GAP cycle, go to PAUSE. If abort is high during GAP, go to IDLE with done.
- PAUSE: tvalid=0, pause_ack=1. When pause_req drops, go to SEND on the next cycle. If abort is high, go to IDLE with done.
- abort and pause_req never truncate a frame. Every frame emitted is complete and ends in tlast.
- stat_beats increments on every accepted beat.

## Timing
- Reset values: tvalid, tlast, tuser, pause_ack, busy, and done are 0. tdata, tkeep, tid, tdest, stat_frames, stat_beats, and all counters are 0. State is IDLE.
- Reset mid-frame: next cycle is IDLE with tvalid=0. The partial frame is abandoned.
- All outputs are registered.
- start sampled at cycle N: busy=1 and tvalid=1 at N+1, first beat with k=0.
- Back-to-back (GAP=0) with tready held high: one beat per cycle, and the first beat of frame f+1 follows the tlast of frame f with no bubble.
- done pulses in the cycle after the final tlast handshake. busy falls in the same cycle.
- pause_ack rises the cycle after the boundary handshake and falls the cycle after pause_req falls.
- The k==len-1 compare uses the latched LEN_W value; frame_len=1 gives tlast on every beat.

## Configuration
- AXIS_FRAME_GEN_BADFRAME_EN defined:
  - tuser[0] = 1 on the last beat of every frame where (f+1) % bad_every == 0, with bad_every≠0.
  - All other tuser bits and beats are 0.
  - bad_every=0 disables injection.
- Not defined: tuser is constant 0 and bad_every is ignored (the port remains, unused).

## Test plan
- Basic frame: start with frame_len=4, frame_cnt=2, seed=0x10, tready=1 -> tdata 10,11,12,13,10,11,12,13; tlast on beats 4 and 8; tid 0,0,0,0,1,1,1,1; done at cycle 10; stat_beats=8.
- Backpressure: frame_len=3; tready low for 5 cycles mid-beat k=1 -> tdata=seed+1 held stable and tvalid stays 1 throughout; total accepted = 3.
- GAP=2, frame_cnt=3, frame_len=1 -> tvalid pattern 1,0,0,1,0,0,1, then done.
- Pause/abort: frame_cnt=0, pause_req raised at k=1 of len-4 frame -> frame finishes with tlast, pause_ack=1, tvalid=0; drop pause_req, then assert abort -> exactly one more full frame, then done, busy=0.
- Edge cases: frame_len=0 -> single-beat frames; start while busy -> ignored; srst_n low mid-frame -> tvalid=0 next cycle, stat counters=0.
- With AXIS_FRAME_GEN_BADFRAME_EN and bad_every=2, frame_cnt=4 -> tuser=1 only on the tlast of frames 1 and 3 (0-based f), and 0 otherwise.
